fsm_down_counter: RTL

//   Loadable FSM down-counter. Complements the existing up-counting FSM.

---
 rtl/fsm_down_counter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fsm_down_counter.sv
// ---------------------------------------------------------------------------
// fsm_down_counter
//
// Loadable down-counter built around a three-state FSM (IDLE, RUN, DONE).
// A load strobe captures load_val and starts a countdown toward zero.
// The counter saturates at zero and never wraps. Arrival at zero is flagged
// by a single-cycle terminal-count pulse (tc). This makes the block a
// programmable delay/timeout source.
//
// Optional feature (compile-time macro):
//   FSM_DOWN_CNT_AUTORELOAD_EN - when defined, DONE restarts the countdown
//   from the last loaded value. This gives a periodic tc with period L+1
//   while en stays high. If the reload value is zero, the FSM drops to IDLE
//   instead. When the macro is not defined, DONE always returns to IDLE and
//   no reload register exists.
//
// Parameters:
//   W         counter width in bits (num and load_val)
//
// Ports:
//   clk       in   single clock, rising edge
//   reset     in   synchronous, active-high reset
//   en        in   count enable (decrements only while in RUN)
//   load      in   load strobe, samples load_val
//   load_val  in   value to load
//   stop      in   abort, returns to IDLE
//   num       out  current count (registered)
//   busy      out  high while in RUN (registered)
//   tc        out  high while in DONE (registered)
//
// Input priority: reset > stop > load > en.
// ---------------------------------------------------------------------------
module fsm_down_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         stop,
    output logic [W-1:0] num,
    output logic         busy,
    output logic         tc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_reg;
    logic [W-1:0]   num_reg;
    logic           busy_reg;
    logic           tc_reg;
`ifdef FSM_DOWN_CNT_AUTORELOAD_EN
    logic [W-1:0]   reload_reg;
`endif

    // busy and tc are registered together with the state.
    // This keeps them glitch-free and exactly aligned with RUN and DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            num_reg    <= '0;
            busy_reg   <= 1'b0;
            tc_reg     <= 1'b0;
`ifdef FSM_DOWN_CNT_AUTORELOAD_EN
            reload_reg <= '0;
`endif
        end else if (stop) begin
            state_reg <= IDLE;
            num_reg   <= '0;
            busy_reg  <= 1'b0;
            tc_reg    <= 1'b0;
        end else if (load) begin
            // A load is honoured in every state and restarts the count.
`ifdef FSM_DOWN_CNT_AUTORELOAD_EN
            reload_reg <= load_val;
`endif
            num_reg <= load_val;
            if (load_val != '0) begin
                state_reg <= RUN;
                busy_reg  <= 1'b1;
                tc_reg    <= 1'b0;
            end else begin
                // Zero-length delay: expire immediately.
                state_reg <= DONE;
                busy_reg  <= 1'b0;
                tc_reg    <= 1'b1;
            end
        end else begin
            case (state_reg)
                RUN: begin
                    if (en) begin
                        if (num_reg > W'(1)) begin
                            num_reg <= num_reg - W'(1);
                        end else begin
                            // Last step lands on zero. Saturate rather than wrap.
                            num_reg   <= '0;
                            state_reg <= DONE;
                            busy_reg  <= 1'b0;
                            tc_reg    <= 1'b1;
                        end
                    end
                end
                DONE: begin
`ifdef FSM_DOWN_CNT_AUTORELOAD_EN
                    if (reload_reg != '0) begin
                        num_reg   <= reload_reg;
                        state_reg <= RUN;
                        busy_reg  <= 1'b1;
                        tc_reg    <= 1'b0;
                    end else begin
                        num_reg   <= '0;
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        tc_reg    <= 1'b0;
                    end
`else
                    num_reg   <= '0;
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    tc_reg    <= 1'b0;
`endif
                end
                default: begin
                    // IDLE, or the unused encoding, which recovers to IDLE.
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    tc_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign num  = num_reg;
    assign busy = busy_reg;
    assign tc   = tc_reg;

endmodule
